// File: rtl/mm_arb_pkg.sv
// Shared types and helpers for the memory-mapped round-robin arbiter.
package mm_arb_pkg;

  typedef enum logic {IDLE, GRANTED} state_t;

  localparam int MAX_MASTERS = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [id_width(MAX_MASTERS)-1:0] master_id_t;

endpackage

// File: rtl/mm_arb_id_fifo.sv
// Small FIFO of master ids for reads accepted by the slave but not yet answered.
// Registered count; head_id is only meaningful while not empty.
module mm_arb_id_fifo
  import mm_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               push_id,
  input  logic                       pop,
  output logic [W-1:0]               head_id,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = id_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-style slave among N masters; one command
// per two cycles, read responses routed back in issue order through an id FIFO.
module mm_rr_arbiter
  import mm_arb_pkg::*;
#(
  parameter int N_MASTERS       = 4,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_MASTERS-1:0]          m_read,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [N_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [N_MASTERS-1:0]          m_readdatavalid,
  output logic                          s_read,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_address,
  output logic [DATA_W-1:0]             s_writedata,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic                          err_unexpected_rsp
);

  localparam int ID_W  = id_width(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t               state;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_vld;
  logic [N_MASTERS-1:0] eligible;
  logic                 gnt_req;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [ID_W-1:0]      head_id;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Read mask looks at the registered count only: a pop this cycle does not unmask.
  assign eligible = m_write | (m_read & {N_MASTERS{fifo_count != CNT_W'(MAX_OUTSTANDING)}});

  always_comb begin
    logic [ID_W-1:0] idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_MASTERS);
      if (eligible[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  always_comb begin
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_writedata   = '0;
    m_waitrequest = '1;
    gnt_req       = 1'b0;
    if (state == GRANTED) begin
      gnt_req       = m_read[gnt_id] | m_write[gnt_id];
      s_write       = m_write[gnt_id];
      s_read        = m_read[gnt_id] & ~m_write[gnt_id];
      s_address     = m_address[int'(gnt_id)*ADDR_W +: ADDR_W];
      s_writedata   = m_writedata[int'(gnt_id)*DATA_W +: DATA_W];
      m_waitrequest[gnt_id] = s_waitrequest;
    end
  end

  assign accept = (s_read | s_write) & ~s_waitrequest;
  assign push   = accept & s_read & ~fifo_full;
  assign pop    = s_readdatavalid & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      gnt_id             <= '0;
      rr_ptr             <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (s_readdatavalid && fifo_empty) err_unexpected_rsp <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_id <= pick_id;
            state  <= GRANTED;
          end
        end
        GRANTED: begin
          if (accept) begin
            rr_ptr <= (gnt_id == ID_W'(N_MASTERS - 1)) ? '0 : gnt_id + 1'b1;
            state  <= IDLE;
          end else if (!gnt_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mm_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .push_id (gnt_id),
    .pop     (pop),
    .head_id (head_id),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    m_readdatavalid = '0;
    if (pop) m_readdatavalid[head_id] = 1'b1;
  end

  assign m_readdata = s_readdata;

endmodule

// File: tb/tb_mm_rr_arbiter.sv
// Directed and randomized bench for mm_rr_arbiter against a transaction-level model.
module tb_mm_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_read, m_write;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_writedata;
  logic [N-1:0]    m_waitrequest, m_readdatavalid;
  logic [DW-1:0]   m_readdata;
  logic            s_read, s_write, s_waitrequest, s_readdatavalid, err_unexpected_rsp;
  logic [AW-1:0]   s_address;
  logic [DW-1:0]   s_writedata, s_readdata;

  int checks = 0;
  int errors = 0;

  // Model: who holds the slave port, where the search starts, ids awaiting a response.
  bit  busy;
  int  gnt;
  int  ptr;
  int  q[$];
  bit  err_m;
  int  obs_gnt[$];
  logic [N-1:0] last_wait = '1;

  mm_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(int i, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    m_read[i]  = r;
    m_write[i] = w;
    m_address[i*AW +: AW]   = a;
    m_writedata[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    m_read = '0; m_write = '0; m_address = '0; m_writedata = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  // Compare all outputs against the model for this cycle, then advance the model.
  task automatic step();
    logic [N-1:0]  e_wait, e_rdv;
    logic          e_r, e_w;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    int pre;
    bit full;
    #1;
    if (!reset_n) begin busy = 0; ptr = 0; q.delete(); err_m = 0; end
    e_r = 0; e_w = 0; e_a = '0; e_d = '0; e_wait = '1; e_rdv = '0;
    if (busy) begin
      e_w = m_write[gnt];
      e_r = m_read[gnt] && !m_write[gnt];
      e_a = m_address[gnt*AW +: AW];
      e_d = m_writedata[gnt*DW +: DW];
      e_wait[gnt] = s_waitrequest;
    end
    if (s_readdatavalid && q.size() > 0) e_rdv[q[0]] = 1'b1;
    chk("s_read", 32'(s_read), 32'(e_r));
    chk("s_write", 32'(s_write), 32'(e_w));
    chk("s_address", 32'(s_address), 32'(e_a));
    chk("s_writedata", s_writedata, e_d);
    chk("m_waitrequest", 32'(m_waitrequest), 32'(e_wait));
    chk("m_readdatavalid", 32'(m_readdatavalid), 32'(e_rdv));
    chk("m_readdata", m_readdata, s_readdata);
    chk("err_unexpected_rsp", 32'(err_unexpected_rsp), 32'(err_m));
    last_wait = m_waitrequest;
    if (!reset_n) return;
    for (int i = 0; i < N; i++) if (!m_waitrequest[i]) obs_gnt.push_back(i);
    pre  = q.size();
    full = (pre == MO);
    if (s_readdatavalid) begin
      if (pre > 0) q.delete(0);
      else err_m = 1;
    end
    if (busy) begin
      if ((e_r || e_w) && !s_waitrequest) begin
        if (e_r) q.push_back(gnt);
        ptr  = (gnt + 1) % N;
        busy = 0;
      end else if (!(m_read[gnt] || m_write[gnt])) begin
        busy = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (!busy && (m_write[idx] || (m_read[idx] && !full))) begin
          busy = 1;
          gnt  = idx;
        end
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin step(); @(negedge clk); end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    step();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_xfer(int i, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    bit done;
    done = 0;
    set_m(i, r, w, a, d);
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (!m_waitrequest[i]) done = 1;
      @(negedge clk);
    end
    set_m(i, 0, 0, '0, '0);
    chk("xfer_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    m_read = '0; m_write = '0;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      s_readdatavalid = 1'b1;
      s_readdata = $urandom;
      step();
      @(negedge clk);
    end
    s_readdatavalid = 1'b0;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic random_phase(int cycles);
    bit active;
    int t;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        active = m_read[i] | m_write[i];
        if (!active || !last_wait[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            t = $urandom_range(0, 15);
            set_m(i, (t < 8) || (t == 15), t >= 8, AW'($urandom), DW'($urandom));
          end else begin
            set_m(i, 0, 0, '0, '0);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          set_m(i, 0, 0, '0, '0);
        end
      end
      s_waitrequest   = ($urandom_range(0, 2) == 0);
      s_readdatavalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      s_readdata      = $urandom;
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    int sw_cnt;
    int bad;
    reset_n = 1'b1;
    clear_inputs();
    #1 reset_n = 1'b0;
    @(negedge clk);
    step();
    chk("rst_s_cmd", {30'd0, s_read, s_write}, 32'd0);
    chk("rst_waitreq", 32'(m_waitrequest), 32'hF);
    chk("rst_rdv", 32'(m_readdatavalid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write: command on the slave exactly one cycle after the request.
    set_m(0, 0, 1, 16'h0010, 32'hDEADBEEF);
    step(); @(negedge clk);
    step();
    chk("t1_s_write", 32'(s_write), 32'd1);
    chk("t1_s_address", 32'(s_address), 32'h0010);
    chk("t1_s_writedata", s_writedata, 32'hDEADBEEF);
    chk("t1_waitreq0", 32'(m_waitrequest[0]), 32'd0);
    @(negedge clk);
    set_m(0, 0, 0, '0, '0);
    step();
    chk("t1_idle_after", 32'(s_write), 32'd0);
    @(negedge clk);

    // Two continuous writers alternate with a bubble between transfers.
    do_reset();
    obs_gnt.delete();
    sw_cnt = 0;
    set_m(0, 0, 1, 16'h1000, 32'h0000_00A0);
    set_m(2, 0, 1, 16'h2000, 32'h0000_00A2);
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_write) sw_cnt++;
      @(negedge clk);
    end
    set_m(0, 0, 0, '0, '0);
    set_m(2, 0, 0, '0, '0);
    chk("t2_write_count", 32'(sw_cnt), 32'd4);
    chk("t2_grant_count", 32'(obs_gnt.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_gnt.size(); k++)
      chk("t2_grant_order", 32'(obs_gnt[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
    run(2);

    // Stalled read holds the port; a competing writer waits.
    set_m(1, 1, 0, 16'h0100, '0);
    s_waitrequest = 1'b1;
    step(); @(negedge clk);
    set_m(2, 0, 1, 16'h0200, 32'h5555_0002);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_s_read_held", 32'(s_read), 32'd1);
      chk("t3_s_address_held", 32'(s_address), 32'h0100);
      chk("t3_all_stalled", 32'(m_waitrequest), 32'hF);
      @(negedge clk);
    end
    s_waitrequest = 1'b0;
    step();
    chk("t3_accept", 32'(m_waitrequest), 32'hD);
    @(negedge clk);
    set_m(1, 0, 0, '0, '0);
    run(2);
    set_m(2, 0, 0, '0, '0);
    s_readdatavalid = 1'b1; s_readdata = 32'h0000_ABCD;
    step();
    chk("t3_rsp_route", 32'(m_readdatavalid), 32'h2);
    @(negedge clk);
    s_readdatavalid = 1'b0;
    run(1);

    // Pipelined reads from 3,1,0 come back in issue order.
    do_xfer(3, 1, 0, 16'h0300, '0);
    do_xfer(1, 1, 0, 16'h0301, '0);
    do_xfer(0, 1, 0, 16'h0302, '0);
    run(1);
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] rd;
      logic [N-1:0]  who;
      rd  = (k == 0) ? 32'h11 : (k == 1) ? 32'h22 : 32'h33;
      who = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0010 : 4'b0001;
      s_readdatavalid = 1'b1; s_readdata = rd;
      step();
      chk("t4_rsp_route", 32'(m_readdatavalid), 32'(who));
      chk("t4_rsp_data", m_readdata, rd);
      @(negedge clk);
      s_readdatavalid = 1'b0;
      run(1);
    end

    // Outstanding limit masks reads but not writes; one pop reopens arbitration.
    for (int i = 0; i < N; i++) do_xfer(i, 1, 0, AW'(16'h0400 + i), '0);
    obs_gnt.delete();
    set_m(2, 1, 0, 16'h0500, '0);
    set_m(0, 0, 1, 16'h0600, 32'h0000_0600);
    run(6);
    set_m(0, 0, 0, '0, '0);
    run(3);
    bad = 0;
    foreach (obs_gnt[k]) if (obs_gnt[k] == 2) bad++;
    chk("t5_read_masked", 32'(bad), 32'd0);
    chk("t5_write_passed", 32'(obs_gnt.size() > 0), 32'd1);
    s_readdatavalid = 1'b1; s_readdata = 32'h77;
    step(); @(negedge clk);
    s_readdatavalid = 1'b0;
    step(); @(negedge clk);
    step();
    chk("t5_grant_after_pop", 32'(m_waitrequest), 32'hB);
    @(negedge clk);
    set_m(2, 0, 0, '0, '0);
    drain();

    // Reset in the middle of a stalled transfer with reads outstanding.
    do_xfer(1, 1, 0, 16'h0700, '0);
    do_xfer(3, 1, 0, 16'h0701, '0);
    set_m(0, 0, 1, 16'h0800, 32'h0000_0800);
    s_waitrequest = 1'b1;
    run(2);
    reset_n = 1'b0;
    step();
    chk("t6_rst_s_write", 32'(s_write), 32'd0);
    chk("t6_rst_waitreq", 32'(m_waitrequest), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    clear_inputs();
    s_readdatavalid = 1'b1; s_readdata = 32'hBAD;
    step();
    chk("t6_stale_no_rdv", 32'(m_readdatavalid), 32'd0);
    @(negedge clk);
    s_readdatavalid = 1'b0;
    step();
    chk("t6_err_set", 32'(err_unexpected_rsp), 32'd1);
    @(negedge clk);
    run(2);
    do_reset();

    random_phase(600);
    drain();
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_rr_arbiter.md
Name: mm_rr_arbiter

Overview:
Round-robin arbiter that shares one memory-mapped slave port among N memory-mapped masters. It uses Avalon-style read, write, waitrequest and readdatavalid signalling. It grants one master at a time and forwards that master's command to the slave. It tracks outstanding reads in an ID FIFO so pipelined read responses return to the issuing master.

Parameters:
N_MASTERS, 4, number of requesting masters (2..8)
ADDR_W, 16, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 4, maximum reads accepted by the slave but not yet answered (power of 2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
m_read  in  N_MASTERS  per-master read request
m_write  in  N_MASTERS  per-master write request
m_address  in  N_MASTERS*ADDR_W  per-master address, master i at slice i
m_writedata  in  N_MASTERS*DATA_W  per-master write data
m_waitrequest  out  N_MASTERS  per-master stall
m_readdata  out  DATA_W  read data, broadcast to all masters
m_readdatavalid  out  N_MASTERS  per-master response strobe
s_read  out  1  slave read
s_write  out  1  slave write
s_address  out  ADDR_W  slave address
s_writedata  out  DATA_W  slave write data
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave response strobe
err_unexpected_rsp  out  1  sticky flag: response arrived with no read outstanding

Behaviour:
- Reset: reset_n is asynchronous and active-low; clk is the clock.
- Reset values: state=IDLE, rr_ptr=0, FIFO empty, s_read=0, s_write=0, s_address=0, s_writedata=0, m_waitrequest=all 1, m_readdatavalid=0, err_unexpected_rsp=0.
- Master i "requests" when m_read[i] or m_write[i] is high.
- Read requests are masked while the FIFO count equals MAX_OUTSTANDING. Write requests are never masked.
- Master asserting both read and write is a protocol violation; write takes precedence.
- State machine, state IDLE:
  - If any unmasked request is present, pick the first requester searching rr_ptr, rr_ptr+1, ... modulo N_MASTERS.
  - Register it in gnt_id and go to GRANTED at the next edge.
  - Otherwise stay in IDLE.
- State machine, state GRANTED:
  - s_read, s_write, s_address and s_writedata are driven combinationally from master gnt_id.
  - m_waitrequest[gnt_id] = s_waitrequest; all other m_waitrequest bits are 1.
  - Acceptance is (s_read|s_write) and !s_waitrequest. On acceptance: rr_ptr <= gnt_id+1 mod N_MASTERS, state <= IDLE.
  - If the granted master drops its request without acceptance: go to IDLE with rr_ptr unchanged.
- Outside GRANTED, all s_* command outputs are 0.
- Latency: a request first seen in cycle 0 appears on s_* in cycle 1.
- Peak throughput is one transfer per 2 cycles; the IDLE bubble is mandatory.
- ID FIFO: an accepted read pushes gnt_id.
- Read response routing:
  - s_readdatavalid pops the FIFO and pulses m_readdatavalid[head] for one cycle.
  - m_readdata = s_readdata, passed through combinationally.
- Simultaneous push and pop: both occur and the count is unchanged.
- Full mask uses the registered count, so there is no same-cycle bypass when a pop frees a slot.
- s_readdatavalid with the FIFO empty: no m_readdatavalid pulse, no pop, err_unexpected_rsp <= 1. The flag clears only on reset.
- Reset asserted mid-transfer or with reads outstanding: immediate return to reset values; in-flight responses are dropped.

Decomposition:
- Package mm_arb_pkg:
  - state enum {IDLE, GRANTED};
  - localparam function for ID width, $clog2(N_MASTERS) minimum 1;
  - master id typedef.
- One sub-module, mm_arb_id_fifo:
  - parameters DEPTH and W;
  - ports push, push_id, pop, head_id, count, full, empty;
  - same asynchronous reset;
  - pointer wrap modulo DEPTH.
- Arbitration, FSM and routing stay in the top.

Test Plan:
1. Master 0 write addr 0x0010 data 0xDEADBEEF, s_waitrequest=0 -> s_write high exactly cycle 1 with those values; m_waitrequest[0] low that cycle; state back to IDLE at cycle 2.
2. Masters 0 and 2 both write continuously, with rr_ptr=0 -> grants alternate 0,2,0,2; s_write asserted every other cycle.
3. Master 1 read, s_waitrequest held high 3 cycles -> s_read, s_address stable 3 cycles and m_waitrequest[1]=1; accepted cycle 4; no other grant meanwhile.
4. Reads from masters 3,1,0 accepted; slave returns 0x11,0x22,0x33 on later cycles -> m_readdatavalid pulses in order [3],[1],[0] with matching m_readdata.
5. Four reads outstanding (MAX_OUTSTANDING=4), master 2 reads and master 0 writes -> master 2 not granted, write proceeds. After one response, master 2 is granted at the next arbitration.
6. reset_n low while GRANTED with 2 reads outstanding -> all outputs at reset values that cycle. A stale s_readdatavalid after reset sets err_unexpected_rsp=1 and produces no m_readdatavalid.
